// File: rtl/alu_pkg.sv
// Shared ALU definitions: op code type, execute FSM states and default datapath sizing.
package alu_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int NREGS_DEF  = 4;

    typedef logic [2:0] alu_op_t;
    localparam alu_op_t OP_ADD = 3'b001;
    localparam alu_op_t OP_SUB = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;
endpackage

// File: rtl/alu_exec_ctrl_regfile.sv
// Purpose: NREGS x DATA_W register file with two operand read ports, a debug read port and one write port.
// Latency: reads are combinational (captured by the caller); writes land on the next rising edge.
// Backpressure: none; writeback beats a same-cycle same-address preload.
module alu_exec_ctrl_regfile
    import alu_pkg::*;
#(
    parameter  int NREGS  = NREGS_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int RA_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RA_W-1:0]   rd_addr1,
    input  logic [RA_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [RA_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              load_en,
    input  logic [RA_W-1:0]   load_addr,
    input  logic [DATA_W-1:0] load_data
);
    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_en && wr_addr == RA_W'(i))
                    mem[i] <= wr_data;
                else if (load_en && load_addr == RA_W'(i))
                    mem[i] <= load_data;
            end
        end
    end

    assign rd_data1 = mem[rd_addr1];
    assign rd_data2 = mem[rd_addr2];
    assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/alu_exec_ctrl.sv
// Purpose: multi-cycle execute controller feeding registered operands to an external combinational ALU.
// Latency: accept at edge N, ALU operands valid after N+1, done during N+2..N+3, rf/zero_flag at N+3.
// Backpressure: instr_ready high only in IDLE; one instruction per 4 cycles.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter  int NREGS  = NREGS_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int RA_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [RA_W-1:0]   instr_rs1,
    input  logic [RA_W-1:0]   instr_rs2,
    input  logic [RA_W-1:0]   instr_rd,
    input  logic              instr_imm_sel,
    input  logic [DATA_W-1:0] instr_imm,
    input  logic              instr_wb,
    output logic [DATA_W-1:0] alu_input1,
    output logic [DATA_W-1:0] alu_input2,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              load_en,
    input  logic [RA_W-1:0]   load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              done,
    output logic              zero_flag
);
    typedef struct packed {
        alu_op_t           op;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
        logic              imm_sel;
        logic [DATA_W-1:0] imm;
        logic              wb;
    } instr_t;

    state_t            state, state_nxt;
    instr_t            instr_q;
    logic [DATA_W-1:0] result_q;
    logic              zq;
    logic [DATA_W-1:0] rd_data1, rd_data2;
    logic              wb_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nxt = ST_READ;
            end
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ALU-facing registers hold their last values between instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= '0;
            alu_input1 <= '0;
            alu_input2 <= '0;
            alu_op     <= '0;
            result_q   <= '0;
            zq         <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid)
                        instr_q <= '{op: instr_op, rs1: instr_rs1, rs2: instr_rs2, rd: instr_rd,
                                     imm_sel: instr_imm_sel, imm: instr_imm, wb: instr_wb};
                end
                ST_READ: begin
                    alu_input1 <= rd_data1;
                    alu_input2 <= instr_q.imm_sel ? instr_q.imm : rd_data2;
                    alu_op     <= instr_q.op;
                end
                ST_EXEC: begin
                    result_q <= alu_result;
                    zq       <= alu_zero;
                end
                ST_WB: zero_flag <= zq;
                default: ;
            endcase
        end
    end

    assign wb_en = (state == ST_WB) && instr_q.wb;

    alu_exec_ctrl_regfile #(
        .NREGS  (NREGS),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr1  (instr_q.rs1),
        .rd_addr2  (instr_q.rs2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (wb_en),
        .wr_addr   (instr_q.rd),
        .wr_data   (result_q),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );
endmodule
